// File: rtl/rsp_s2_prep_ahbic_pkg.sv
// Shared encodings and helpers for the AHB interconnect decoder and its default slave.
package rsp_s2_prep_ahbic_pkg;

    localparam int PORT_W = 4;
    localparam int MAX_MI = 8;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_e;

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_ERR1 = 2'd1,
        D_ERR2 = 2'd2
    } dflt_state_e;

    // The default slave sits one index past the last real output port.
    function automatic logic [PORT_W-1:0] dflt_port(input int num_mi);
        return PORT_W'(num_mi);
    endfunction

endpackage

// File: rtl/rsp_s2_prep_ahbic_dflt_err.sv
// Default slave: two-cycle ERROR response for unmapped transfers, plus
// capture of the offending address and a saturating error count.
//
// state  | meaning
// D_IDLE | no error pending, zero-wait OKAY
// D_ERR1 | first ERROR cycle, HREADYOUT low
// D_ERR2 | second ERROR cycle, HREADYOUT high
module rsp_s2_prep_ahbic_dflt_err
    import rsp_s2_prep_ahbic_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 xfer_i,
    input  logic                 err_clr_i,
    input  logic [31:10]         addr_i,
    output logic                 hreadyout_o,
    output logic [1:0]           hresp_o,
    output logic [31:10]         err_addr_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    dflt_state_e state_q, state_d;
    logic [31:10] err_addr_q, err_addr_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic enter_err1;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= D_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            D_IDLE:  if (xfer_i) state_d = D_ERR1;
            D_ERR1:  state_d = D_ERR2;
            D_ERR2:  state_d = xfer_i ? D_ERR1 : D_IDLE;
            default: state_d = D_IDLE;
        endcase
    end

    always_comb begin
        hreadyout_o = 1'b1;
        hresp_o     = HRESP_OKAY;
        case (state_q)
            D_ERR1: begin
                hreadyout_o = 1'b0;
                hresp_o     = HRESP_ERROR;
            end
            D_ERR2:  hresp_o = HRESP_ERROR;
            default: ;
        endcase
    end

    // D_ERR1 always exits to D_ERR2, so a next state of D_ERR1 is always an entry.
    assign enter_err1 = (state_d == D_ERR1);

    always_comb begin
        err_addr_d = enter_err1 ? addr_i : err_addr_q;
        err_cnt_d  = err_cnt_q;
        if (err_clr_i) begin
            err_cnt_d = enter_err1 ? ERR_CNT_W'(1) : '0;
        end else if (enter_err1 && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            err_addr_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            err_addr_q <= err_addr_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign err_addr_o = err_addr_q;
    assign err_cnt_o  = err_cnt_q;

endmodule

// File: rtl/rsp_s2_prep_ahbic_decp.sv
// AHB address decoder and response mux: one-hot select in the address phase,
// registered data-phase port steering the response mux, and a default slave.
module rsp_s2_prep_ahbic_decp
    import rsp_s2_prep_ahbic_pkg::*;
#(
    parameter int                   NUM_MI      = 3,
    parameter logic [22*NUM_MI-1:0] REGION_BASE = {22'h080000, 22'h040000, 22'h000000},
    parameter logic [22*NUM_MI-1:0] REGION_MASK = {3{22'h3C0000}},
    parameter int                   ERR_CNT_W   = 8
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic                   HREADYS,
    input  logic                   sel_dec,
    input  logic [31:10]           decode_addr_dec,
    input  logic [1:0]             trans_dec,
    input  logic [NUM_MI-1:0]      active_mi,
    input  logic [NUM_MI-1:0]      readyout_mi,
    input  logic [2*NUM_MI-1:0]    resp_mi,
    input  logic [32*NUM_MI-1:0]   rdata_mi,
    output logic [NUM_MI-1:0]      sel_mi,
    output logic                   active_dec,
    output logic                   HREADYOUTS,
    output logic [1:0]             HRESPS,
    output logic [31:0]            HRDATAS,
    input  logic                   err_clr,
    output logic [31:10]           err_addr,
    output logic [ERR_CNT_W-1:0]   err_cnt
);

    if (NUM_MI < 1 || NUM_MI > MAX_MI) begin : g_bad_num_mi
        $fatal(1, "rsp_s2_prep_ahbic_decp: NUM_MI must be 1..8");
    end

    localparam logic [PORT_W-1:0] DFLT = dflt_port(NUM_MI);

    logic [PORT_W-1:0] dec_port, addr_port;
    logic [PORT_W-1:0] data_port_q, data_port_d;
    logic              dflt_xfer, dflt_ready;
    logic [1:0]        dflt_resp;

    // Scan high to low so the lowest matching region is the one that sticks.
    always_comb begin
        dec_port = DFLT;
        for (int i = NUM_MI - 1; i >= 0; i--) begin
            if ((decode_addr_dec & REGION_MASK[22*i +: 22]) ==
                (REGION_BASE[22*i +: 22] & REGION_MASK[22*i +: 22])) begin
                dec_port = PORT_W'(i);
            end
        end
    end

    assign addr_port = (trans_dec == HTRANS_IDLE) ? data_port_q : dec_port;

    always_comb begin
        sel_mi     = '0;
        active_dec = 1'b1;
        for (int i = 0; i < NUM_MI; i++) begin
            if (addr_port == PORT_W'(i)) begin
                sel_mi[i]  = sel_dec;
                active_dec = active_mi[i];
            end
        end
    end

    assign data_port_d = HREADYS ? addr_port : data_port_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            data_port_q <= '0;
        end else begin
            data_port_q <= data_port_d;
        end
    end

    always_comb begin
        HREADYOUTS = dflt_ready;
        HRESPS     = dflt_resp;
        HRDATAS    = '0;
        for (int i = 0; i < NUM_MI; i++) begin
            if (data_port_q == PORT_W'(i)) begin
                HREADYOUTS = readyout_mi[i];
                HRESPS     = resp_mi[2*i +: 2];
                HRDATAS    = rdata_mi[32*i +: 32];
            end
        end
    end

    assign dflt_xfer = sel_dec & HREADYS & trans_dec[1] & (addr_port == DFLT);

    rsp_s2_prep_ahbic_dflt_err #(
        .ERR_CNT_W (ERR_CNT_W)
    ) u_dflt_err (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .xfer_i      (dflt_xfer),
        .err_clr_i   (err_clr),
        .addr_i      (decode_addr_dec),
        .hreadyout_o (dflt_ready),
        .hresp_o     (dflt_resp),
        .err_addr_o  (err_addr),
        .err_cnt_o   (err_cnt)
    );

endmodule

// File: doc/rsp_s2_prep_ahbic_decp.md
RSP_S2_PREP_AHBIC_DECP -- requirements
Module: rsp_s2_prep_ahbic_decp

Interface
REQ-001 SHALL have parameter NUM_MI, default 3, meaning number of output ports (1..8).
REQ-002 SHALL have parameter REGION_BASE, default {22'h080000,22'h040000,22'h000000}, meaning per-port 22-bit base, port i at bits [22i+21:22i].
REQ-003 SHALL have parameter REGION_MASK, default {3{22'h3C0000}}, meaning per-port 22-bit compare mask, same packing.
REQ-004 SHALL have parameter ERR_CNT_W, default 8, meaning error counter width.
REQ-005 SHALL have port HCLK, input, 1, meaning AHB clock.
REQ-006 SHALL have port HRESETn, input, 1, meaning reset, asynchronous, active-low.
REQ-007 SHALL have port HREADYS, input, 1, meaning input-stage transfer done.
REQ-008 SHALL have port sel_dec, input, 1, meaning HSEL from input stage.
REQ-009 SHALL have port decode_addr_dec, input, [31:10], meaning decode address.
REQ-010 SHALL have port trans_dec, input, 2, meaning HTRANS.
REQ-011 SHALL have ports active_mi, readyout_mi, resp_mi and rdata_mi, inputs, widths NUM_MI, NUM_MI, 2*NUM_MI and 32*NUM_MI, meaning per-port active, HREADYOUT, HRESP and HRDATA.
REQ-012 SHALL have port sel_mi, output, NUM_MI, meaning one-hot port select.
REQ-013 SHALL have ports active_dec, HREADYOUTS, HRESPS and HRDATAS, outputs, widths 1, 1, 2 and 32, meaning the selected port's response.
REQ-014 SHALL have port err_clr, input, 1, meaning synchronous clear of the error counter.
REQ-015 SHALL have port err_addr, output, [31:10], meaning address of the last unmapped access.
REQ-016 SHALL have port err_cnt, output, ERR_CNT_W, meaning count of unmapped accesses, saturating.

Function
REQ-017 SHALL decode port i as matched when (decode_addr_dec & MASK_i) == (BASE_i & MASK_i); the lowest matching index wins; no match selects the default slave (index NUM_MI).
REQ-018 SHALL override the decode with the registered data port when trans_dec==IDLE, keeping a port held across IDLE cycles.
REQ-019 SHALL drive sel_mi[addr_port]=1 only when sel_dec=1; all other bits are 0.
REQ-020 SHALL drive active_dec from active_mi[addr_port], or 1 when the default slave is addressed.
REQ-021 SHALL register data_port <= addr_port on every HCLK edge with HREADYS=1 and hold it otherwise.
REQ-022 SHALL mux HREADYOUTS, HRESPS and HRDATAS combinationally from data_port; the default slave returns HRDATAS=0.
REQ-023 SHALL implement the default slave as FSM D_IDLE, D_ERR1, D_ERR2.
REQ-024 SHALL move D_IDLE->D_ERR1 when the default slave is selected with HREADYS=1 and trans_dec[1]=1 (NONSEQ/SEQ).
REQ-025 SHALL have D_ERR1 output HREADYOUT=0, HRESP=ERROR and always move to D_ERR2.
REQ-026 SHALL have D_ERR2 output HREADYOUT=1, HRESP=ERROR; it moves to D_ERR1 if a new qualifying transfer is accepted, else to D_IDLE.
REQ-027 SHALL have D_IDLE output HREADYOUT=1, HRESP=OKAY; IDLE/BUSY transfers to the default slave get a zero-wait OKAY.
REQ-028 SHALL, on each D_ERR1 entry, capture decode_addr_dec into err_addr and increment err_cnt, saturating at all-ones.
REQ-029 SHALL set err_cnt to 0 on err_clr=1, or to 1 if a new D_ERR1 entry occurs in the same cycle; err_addr is unaffected by err_clr.
REQ-030 SHALL have a decode-to-sel_mi path that is purely combinational (zero latency), with the data phase aligned one accepted HREADYS later.

Reset
REQ-031 SHALL, while HRESETn=0, set data_port=0, FSM=D_IDLE, err_addr=0 and err_cnt=0.
REQ-032 SHALL, with sel_dec=0 during reset, output sel_mi=0, HREADYOUTS=readyout_mi[0], HRESPS=resp_mi[1:0] and HRDATAS=rdata_mi[31:0].
REQ-033 SHALL return to D_IDLE from any state on reset assertion mid-error, with no further ERROR cycle after release.

Structure
REQ-034 SHALL place HTRANS and HRESP encodings, the FSM state typedef and default-slave index helper constants in rsp_s2_prep_ahbic_pkg.
REQ-035 SHALL implement the FSM and error capture as sub-module rsp_s2_prep_ahbic_dflt_err, instantiated once.
REQ-036 SHALL check parameters at elaboration and fail if NUM_MI is outside 1..8.

Verification
REQ-037 SHALL cover: NONSEQ to 22'h040123 (0x1004_8C00) -> sel_mi=3'b010; the next data phase returns rdata_mi[63:32] and readyout_mi[1].
REQ-038 SHALL cover: NONSEQ to 22'h0C0000 (0x3000_0000) -> sel_mi=0, one HREADYOUTS=0/ERROR cycle, then HREADYOUTS=1/ERROR, err_addr=22'h0C0000, err_cnt=1.
REQ-039 SHALL cover: back-to-back unmapped NONSEQs accepted in D_ERR2 -> ERR1, ERR2, ERR1, ERR2 sequence, err_cnt=2.
REQ-040 SHALL cover: err_clr coincident with a D_ERR1 entry -> err_cnt=1; 300 errors with ERR_CNT_W=8 -> err_cnt=255.
REQ-041 SHALL cover: data_port=2 with trans_dec=IDLE and decode address 0 -> sel_mi=3'b100 held; readyout_mi[2]=0 stalls HREADYOUTS=0 and data_port stays 2.
REQ-042 SHALL cover: HRESETn asserted in D_ERR1 -> HREADYOUTS=1, HRESPS=OKAY after release, err_cnt=0.
